uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BPS, default 115200, meaning line bit rate; COUNT = CLK_FREQ/BPS, HALF_COUNT = COUNT/2.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning payload bits per frame.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, legal 1 or 2, meaning stop bits checked per frame.
REQ-006 The block SHALL have port sys_clk, input, width 1, meaning the single system clock; all logic on its rising edge.
REQ-007 The block SHALL have port sys_rst_n, input, width 1, meaning reset, asynchronous and active-low.
REQ-008 The block SHALL have port uart_rxd_i, input, width 1, meaning asynchronous serial line, idle high.
REQ-009 The block SHALL have port uart_rx_valid_o, output, width 1, meaning a one-cycle pulse per completed frame.
REQ-010 The block SHALL have port uart_rxdata_o, output, width DATA_BITS, meaning received payload, LSB first on the line.
REQ-011 The block SHALL have ports uart_parity_err_o, uart_frame_err_o and uart_break_o, each output, width 1, meaning per-frame status, all qualified by uart_rx_valid_o.
REQ-012 The block SHALL have port uart_busy_o, output, width 1, meaning high in every state other than IDLE.

Function
REQ-013 uart_rxd_i SHALL pass through a 2-flop synchronizer; start detection SHALL be a 1-to-0 transition of the synchronized line.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PAR, STOP and BRK_WAIT.
REQ-015 A bit counter SHALL count 1..COUNT per bit period; each bit value SHALL be the majority of 3 samples taken at counts HALF_COUNT-1, HALF_COUNT and HALF_COUNT+1.
REQ-016 IDLE->START on a start edge; in START, majority 1 SHALL count as a false start: return to IDLE, no valid pulse.
REQ-017 START->DATA after COUNT; DATA SHALL capture DATA_BITS bits LSB first, then go to PAR if PARITY!=0, else STOP.
REQ-018 PAR: parity_err SHALL be set if the XOR of data and parity bit is 1 (even) or 0 (odd); uart_parity_err_o SHALL be 0 when PARITY=0.
REQ-019 STOP: each stop bit SHALL be sampled; frame_err SHALL be set if any stop bit samples 0.
REQ-020 The last stop bit SHALL end at its centre sample (count HALF_COUNT+1), not at COUNT, to tolerate baud deviation.
REQ-021 Exactly 1 cycle after that final sample, uart_rx_valid_o SHALL pulse high for 1 cycle with uart_rxdata_o and all flags stable.
REQ-022 uart_rxdata_o and the flags SHALL hold their values until the next valid pulse.
REQ-023 Break condition: all data bits 0, parity bit 0 (if present) and stop bits 0 -> uart_break_o=1 and uart_frame_err_o=1 with the valid pulse; the FSM SHALL then enter BRK_WAIT.
REQ-024 BRK_WAIT SHALL return to IDLE only after the synchronized line has been high for one full COUNT; no start is detected meanwhile.
REQ-025 After a non-break frame the FSM SHALL return to IDLE immediately, so a start edge half a bit later is accepted (back-to-back frames).
REQ-026 The bit counter SHALL be 16 bits wide; COUNT SHALL not exceed 65535.

Reset
REQ-027 Asserting sys_rst_n low SHALL, asynchronously: set FSM=IDLE; clear all counters, uart_rx_valid_o, uart_rxdata_o, all flags and uart_busy_o; set the synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first start edge after deassertion SHALL begin a fresh frame.

Structure
REQ-029 Package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state encoding.
REQ-030 The synchronizer plus 3-sample majority filter SHALL be a sub-module named uart_rx_sync.

Verification (CLK_FREQ=50_000_000, BPS=115200, COUNT=434)
REQ-031 8N1 byte 0xA5 -> one valid pulse, uart_rxdata_o=0xA5, all flags 0, valid 1 cycle after the stop-bit centre.
REQ-032 PARITY=1, byte 0x07 sent with parity bit 0 -> valid, data 0x07, uart_parity_err_o=1.
REQ-033 100-cycle low glitch on an idle line -> no valid pulse, uart_busy_o low again within COUNT+2 cycles.
REQ-034 8N2, byte 0x3C with second stop bit 0 -> valid, data 0x3C, uart_frame_err_o=1, uart_break_o=0.
REQ-035 Line low for 12 bit times, then high -> one valid with uart_break_o=1, data 0; no further valid until the line has been high for 434 cycles.
REQ-036 sys_rst_n pulsed low during data bit 4, then bytes 0x55 and 0xAA sent back-to-back -> all outputs 0 during reset, then two valid pulses with 0x55 and 0xAA, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the configurable UART receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BRK_WAIT
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line synchronizer, start-edge detector and 3-sample majority filter.
// maj is meaningful in the cycle where cnt == HALF+1 (third sample taken live).
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter logic [15:0] HALF = 16'd217
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic [15:0] cnt,
  output logic        line,
  output logic        fall,
  output logic        maj
);

  logic meta;
  logic line_d;
  logic s0;
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      line   <= 1'b1;
      line_d <= 1'b1;
      s0     <= 1'b1;
      s1     <= 1'b1;
    end else begin
      meta   <= rxd;
      line   <= meta;
      line_d <= line;
      if (cnt == HALF - 16'd1) s0 <= line;
      if (cnt == HALF) s1 <= line;
    end
  end

  assign fall = line_d & ~line;
  assign maj  = majority3(s0, s1, line);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional even/odd parity,
// 1 or 2 stop bits, with frame-error and line-break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BPS       = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd_i,
  output logic                 uart_rx_valid_o,
  output logic [DATA_BITS-1:0] uart_rxdata_o,
  output logic                 uart_parity_err_o,
  output logic                 uart_frame_err_o,
  output logic                 uart_break_o,
  output logic                 uart_busy_o
);

  localparam logic [15:0] CNT_MAX    = 16'(CLK_FREQ / BPS);
  localparam logic [15:0] CNT_HALF   = 16'(CLK_FREQ / BPS / 2);
  localparam logic [15:0] CNT_DECIDE = CNT_HALF + 16'd1;
  localparam logic [3:0]  LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP  = 1'(STOP_BITS - 1);

  rx_state_t            state;
  logic [15:0]          cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 stop_zero;
  logic                 frame_acc;

  logic line;
  logic fall;
  logic maj;
  logic par_calc;
  logic perr_next;
  logic brk_next;

  uart_rx_sync #(
    .HALF(CNT_HALF)
  ) u_sync (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .rxd  (uart_rxd_i),
    .cnt  (cnt),
    .line (line),
    .fall (fall),
    .maj  (maj)
  );

  // Frame status as it stands at the centre of the final stop bit.
  always_comb begin
    par_calc  = (^shift) ^ par_bit;
    perr_next = 1'b0;
    if (PARITY == PAR_EVEN) perr_next = par_calc;
    else if (PARITY == PAR_ODD) perr_next = ~par_calc;
    brk_next = (shift == '0) && ((PARITY == PAR_NONE) || !par_bit) && stop_zero && !maj;
  end

  assign uart_busy_o = (state != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      stop_idx          <= 1'b0;
      shift             <= '0;
      par_bit           <= 1'b0;
      stop_zero         <= 1'b0;
      frame_acc         <= 1'b0;
      uart_rx_valid_o   <= 1'b0;
      uart_rxdata_o     <= '0;
      uart_parity_err_o <= 1'b0;
      uart_frame_err_o  <= 1'b0;
      uart_break_o      <= 1'b0;
    end else begin
      uart_rx_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= START;
            cnt   <= 16'd1;
          end
        end

        START: begin
          if (cnt == CNT_DECIDE && maj) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= DATA;
            cnt     <= 16'd1;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == CNT_DECIDE) shift <= {maj, shift[DATA_BITS-1:1]};
          if (cnt == CNT_MAX) begin
            cnt <= 16'd1;
            if (bit_idx == LAST_BIT) begin
              state     <= (PARITY != PAR_NONE) ? PAR : STOP;
              stop_idx  <= 1'b0;
              stop_zero <= 1'b1;
              frame_acc <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        PAR: begin
          if (cnt == CNT_DECIDE) par_bit <= maj;
          if (cnt == CNT_MAX) begin
            state <= STOP;
            cnt   <= 16'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // The last stop bit finishes at its centre so a fast sender's next
        // start edge is never missed.
        STOP: begin
          if (cnt == CNT_DECIDE) begin
            if (stop_idx == LAST_STOP) begin
              uart_rx_valid_o   <= 1'b1;
              uart_rxdata_o     <= shift;
              uart_parity_err_o <= perr_next;
              uart_frame_err_o  <= frame_acc | ~maj;
              uart_break_o      <= brk_next;
              cnt               <= '0;
              state             <= brk_next ? BRK_WAIT : IDLE;
            end else begin
              frame_acc <= frame_acc | ~maj;
              stop_zero <= stop_zero & ~maj;
              cnt       <= cnt + 16'd1;
            end
          end else if (cnt == CNT_MAX) begin
            cnt      <= 16'd1;
            stop_idx <= stop_idx + 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        BRK_WAIT: begin
          if (!line) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances share clock and reset.
module tb_uart_rx_cfg;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BPS      = 115200;
  localparam int COUNT    = CLK_FREQ / BPS;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxd;
  wire  [2:0] valid;
  wire  [2:0] perr;
  wire  [2:0] ferr;
  wire  [2:0] brk;
  wire  [2:0] busy;
  wire  [7:0] data0;
  wire  [7:0] data1;
  wire  [7:0] data2;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cycle        = 0;
  int   start_cycle[3];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #10 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BPS(BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd_i(rxd[0]), .uart_rx_valid_o(valid[0]),
    .uart_rxdata_o(data0), .uart_parity_err_o(perr[0]), .uart_frame_err_o(ferr[0]),
    .uart_break_o(brk[0]), .uart_busy_o(busy[0]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BPS(BPS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8e1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd_i(rxd[1]), .uart_rx_valid_o(valid[1]),
    .uart_rxdata_o(data1), .uart_parity_err_o(perr[1]), .uart_frame_err_o(ferr[1]),
    .uart_break_o(brk[1]), .uart_busy_o(busy[1]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BPS(BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_8n2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd_i(rxd[2]), .uart_rx_valid_o(valid[2]),
    .uart_rxdata_o(data2), .uart_parity_err_o(perr[2]), .uart_frame_err_o(ferr[2]),
    .uart_break_o(brk[2]), .uart_busy_o(busy[2]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Start edge to valid: 2 sync flops + edge flop, then frame bits up to
  // the final stop bit plus its centre sample.
  function automatic int expLatency(input int idx);
    int n;
    n = (idx == 0) ? 9 : 10;
    return COUNT * n + (COUNT / 2 + 1) + 3;
  endfunction

  task automatic pushExpected(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic checkFrame(input int idx, input logic [7:0] d, input logic pe,
                            input logic fe, input logic bk);
    exp_t e;
    logic have;
    have = 1'b0;
    e    = '0;
    case (idx)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    checkOutput($sformatf("dut%0d_expected_pending", idx), 32'(have), 32'd1);
    if (have) begin
      checkOutput($sformatf("dut%0d_data", idx), 32'(d), 32'(e.data));
      checkOutput($sformatf("dut%0d_parity_err", idx), 32'(pe), 32'(e.perr));
      checkOutput($sformatf("dut%0d_frame_err", idx), 32'(fe), 32'(e.ferr));
      checkOutput($sformatf("dut%0d_break", idx), 32'(bk), 32'(e.brk));
      checkOutput($sformatf("dut%0d_latency", idx), 32'(cycle - start_cycle[idx]),
                  32'(expLatency(idx)));
    end
  endtask

  always @(negedge clk) begin
    if (valid[0]) checkFrame(0, data0, perr[0], ferr[0], brk[0]);
    if (valid[1]) checkFrame(1, data1, perr[1], ferr[1], brk[1]);
    if (valid[2]) checkFrame(2, data2, perr[2], ferr[2], brk[2]);
  end

  task automatic driveBit(input int idx, input logic v);
    rxd[idx] = v;
    repeat (COUNT) @(negedge clk);
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] d, input logic par_val,
                               input logic [1:0] stop_vals);
    exp_t e;
    logic par_on;
    int   nstop;
    par_on = (idx == 1);
    nstop  = (idx == 2) ? 2 : 1;
    e.data = d;
    e.perr = par_on ? ((^d) ^ par_val) : 1'b0;
    e.ferr = !stop_vals[0] || (nstop == 2 && !stop_vals[1]);
    e.brk  = (d == 8'h00) && (!par_on || !par_val) && !stop_vals[0] &&
             (nstop == 1 || !stop_vals[1]);
    pushExpected(idx, e);
    @(negedge clk);
    start_cycle[idx] = cycle;
    driveBit(idx, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(idx, d[i]);
    if (par_on) driveBit(idx, par_val);
    for (int i = 0; i < nstop; i++) driveBit(idx, stop_vals[i]);
    rxd[idx] = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid[0]), 32'd0);
    checkOutput({tag, "_data"}, 32'(data0), 32'd0);
    checkOutput({tag, "_flags"}, 32'({perr[0], ferr[0], brk[0]}), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy[0]), 32'd0);
  endtask

  initial begin
    repeat (120000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   waited;
    exp_t e;
    rst_n = 1'b0;
    rxd   = 3'b111;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (COUNT) @(negedge clk);

    applyStimulus(0, 8'hA5, 1'b0, 2'b11);
    repeat (COUNT) @(negedge clk);

    applyStimulus(1, 8'h07, 1'b0, 2'b11);
    repeat (COUNT) @(negedge clk);
    applyStimulus(1, 8'h07, 1'b1, 2'b11);
    repeat (COUNT) @(negedge clk);

    // Short low glitch must be rejected as a false start.
    rxd[0] = 1'b0;
    repeat (100) @(negedge clk);
    rxd[0] = 1'b1;
    checkOutput("glitch_busy", 32'(busy[0]), 32'd1);
    waited = 100;
    while (busy[0] && waited < COUNT + 2) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("glitch_idle", 32'(busy[0]), 32'd0);
    repeat (COUNT) @(negedge clk);

    applyStimulus(2, 8'h3C, 1'b0, 2'b01);
    repeat (COUNT) @(negedge clk);
    applyStimulus(2, 8'h3C, 1'b0, 2'b11);
    repeat (COUNT) @(negedge clk);

    // Break: 12 bit times low, then a hold-off that restarts on any low.
    e = '{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
    pushExpected(0, e);
    @(negedge clk);
    start_cycle[0] = cycle;
    rxd[0] = 1'b0;
    repeat (12 * COUNT) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (300) @(negedge clk);
    rxd[0] = 1'b0;
    repeat (50) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("brk_wait_busy", 32'(busy[0]), 32'd1);
    repeat (200) @(negedge clk);
    checkOutput("brk_wait_exit", 32'(busy[0]), 32'd0);

    applyStimulus(0, 8'h5A, 1'b0, 2'b11);
    repeat (COUNT) @(negedge clk);
    checkOutput("hold_data", 32'(data0), 32'h5A);
    checkOutput("hold_break", 32'(brk[0]), 32'd0);

    // Reset in the middle of data bit 4 discards the partial frame.
    @(negedge clk);
    driveBit(0, 1'b0);
    for (int i = 0; i < 4; i++) driveBit(0, 1'b1);
    rxd[0] = 1'b0;
    repeat (COUNT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checkResetOutputs("midframe_reset");
    rxd[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * COUNT) @(negedge clk);

    applyStimulus(0, 8'h55, 1'b0, 2'b11);
    applyStimulus(0, 8'hAA, 1'b0, 2'b11);
    repeat (COUNT) @(negedge clk);

    checkOutput("dut0_queue_drained", 32'(q0.size()), 32'd0);
    checkOutput("dut1_queue_drained", 32'(q1.size()), 32'd0);
    checkOutput("dut2_queue_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
